// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer: next-PC source select and
// the RAS occupancy-count width helper.
package pc_pkg;

   typedef enum logic [1:0] {
      PC_SEL_SEQ,
      PC_SEL_BR,
      PC_SEL_JMP,
      PC_SEL_RET
   } pc_sel_e;

   // Count must represent 0..depth inclusive, hence one bit beyond the pointer.
   function automatic int unsigned ras_cnt_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push while full overwrites the oldest entry
// and sets a sticky overflow flag. Clear empties the stack without touching storage.
module ras_stack
   import pc_pkg::*;
#(
   parameter int unsigned PC_W      = 8,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  logic            clear,
   input  logic [PC_W-1:0] wdata,
   output logic [PC_W-1:0] top,
   output logic            empty,
   output logic            full,
   output logic            overflow
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = ras_cnt_w(RAS_DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

   logic [PC_W-1:0]  mem [RAS_DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d, top_idx;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   // ptr addresses the next free slot; the top is the slot just below it.
   assign top_idx  = ptr_q - PTR_W'(1);
   assign top      = mem[top_idx];
   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == DEPTH_C);
   assign overflow = ovf_q;

   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clear) begin
         cnt_d = '0;
      end else if (push) begin
         ptr_d = ptr_q + PTR_W'(1);
         if (full) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (pop && !empty) begin
         ptr_d = top_idx;
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem[ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection with a return-address stack. Define PC_RAS_CHECK_EN to
// verify popped return addresses against jr_target and flush the RAS on mismatch.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int unsigned PC_W      = 8,
   parameter int unsigned PC_STEP   = 1,
   parameter int unsigned RESET_PC  = 0,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   input  logic            jump,
   input  logic            jal,
   input  logic [PC_W-1:0] jump_target,
   input  logic            ret,
   input  logic [PC_W-1:0] jr_target,
   output logic [PC_W-1:0] pc_output,
   output logic [PC_W-1:0] pc_plus_step,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            ras_overflow,
   output logic            ras_underflow,
   output logic            ras_mismatch
);

   localparam logic [PC_W-1:0] STEP_C  = PC_W'(PC_STEP);
   localparam logic [PC_W-1:0] RESET_C = PC_W'(RESET_PC);

   pc_sel_e         sel;
   logic [PC_W-1:0] pc_q, pc_d, ret_target, ras_top;
   logic            push, pop, clear;
   logic            unf_d, unf_q;
`ifdef PC_RAS_CHECK_EN
   logic            mm_d, mm_q;
`endif

   assign pc_output    = pc_q;
   assign pc_plus_step = pc_q + STEP_C;

   ras_stack #(
      .PC_W      (PC_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .clear    (clear),
      .wdata    (pc_plus_step),
      .top      (ras_top),
      .empty    (ras_empty),
      .full     (ras_full),
      .overflow (ras_overflow)
   );

   always_comb begin
      sel        = PC_SEL_SEQ;
      push       = 1'b0;
      pop        = 1'b0;
      clear      = 1'b0;
      unf_d      = 1'b0;
      ret_target = jr_target;
`ifdef PC_RAS_CHECK_EN
      mm_d       = 1'b0;
`endif
      if (!stall) begin
         if (jump || jal) begin
            sel  = PC_SEL_JMP;
            push = jal;
         end else if (ret) begin
            sel = PC_SEL_RET;
            if (ras_empty) begin
               unf_d = 1'b1;
            end else begin
`ifdef PC_RAS_CHECK_EN
               // A stale prediction means the stack is out of sync; drop it all.
               if (ras_top != jr_target) begin
                  clear = 1'b1;
                  mm_d  = 1'b1;
               end else begin
                  pop        = 1'b1;
                  ret_target = ras_top;
               end
`else
               pop        = 1'b1;
               ret_target = ras_top;
`endif
            end
         end else if (branch_taken) begin
            sel = PC_SEL_BR;
         end
      end

      pc_d = pc_q;
      if (!stall) begin
         unique case (sel)
            PC_SEL_SEQ: pc_d = pc_plus_step;
            PC_SEL_BR:  pc_d = branch_target;
            PC_SEL_JMP: pc_d = jump_target;
            PC_SEL_RET: pc_d = ret_target;
            default:    pc_d = pc_plus_step;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q  <= RESET_C;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         unf_q <= unf_d;
      end
   end

   assign ras_underflow = unf_q;

`ifdef PC_RAS_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mm_q <= 1'b0;
      end else begin
         mm_q <= mm_d;
      end
   end

   assign ras_mismatch = mm_q;
`else
   assign ras_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_pc_sequencer;

   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, jal = 1'b0, ret = 1'b0;
   logic [7:0] branch_target = '0, jump_target = '0, jr_target = '0;
   logic [7:0] pc_output, pc_plus_step;
   logic       ras_empty, ras_full, ras_overflow, ras_underflow, ras_mismatch;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   int         m_pc;
   logic [7:0] m_ras[$];
   bit         m_ovf, m_unf, m_mm;

   always #5 clk = ~clk;

   pc_sequencer #(
      .PC_W      (8),
      .PC_STEP   (1),
      .RESET_PC  (0),
      .RAS_DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jal           (jal),
      .jump_target   (jump_target),
      .ret           (ret),
      .jr_target     (jr_target),
      .pc_output     (pc_output),
      .pc_plus_step  (pc_plus_step),
      .ras_empty     (ras_empty),
      .ras_full      (ras_full),
      .ras_overflow  (ras_overflow),
      .ras_underflow (ras_underflow),
      .ras_mismatch  (ras_mismatch)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 0;
      m_ras.delete();
      m_ovf = 0;
      m_unf = 0;
      m_mm  = 0;
   endtask

   task automatic model_step();
      int         pps;
      logic [7:0] t;
      pps   = (m_pc + 1) % 256;
      m_unf = 0;
      m_mm  = 0;
      if (stall) return;
      if (jump || jal) begin
         if (jal) begin
            if (m_ras.size() == DEPTH) begin
               void'(m_ras.pop_front());
               m_ovf = 1;
            end
            m_ras.push_back(8'(pps));
         end
         m_pc = int'(jump_target);
      end else if (ret) begin
         if (m_ras.size() > 0) begin
            t = m_ras.pop_back();
`ifdef PC_RAS_CHECK_EN
            if (t != jr_target) begin
               m_ras.delete();
               m_mm = 1;
               m_pc = int'(jr_target);
            end else begin
               m_pc = int'(t);
            end
`else
            m_pc = int'(t);
`endif
         end else begin
            m_pc  = int'(jr_target);
            m_unf = 1;
         end
      end else if (branch_taken) begin
         m_pc = int'(branch_target);
      end else begin
         m_pc = pps;
      end
   endtask

   task automatic compare_all();
      check("pc_output", 32'(pc_output), 32'(m_pc));
      check("pc_plus_step", 32'(pc_plus_step), 32'((m_pc + 1) % 256));
      check("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
      check("ras_full", 32'(ras_full), 32'(m_ras.size() == DEPTH));
      check("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
      check("ras_underflow", 32'(ras_underflow), 32'(m_unf));
      check("ras_mismatch", 32'(ras_mismatch), 32'(m_mm));
   endtask

   // One clock: drive inputs now (just after an edge), step model at the edge, compare after.
   task automatic cyc(input bit s, input bit br, input logic [7:0] bt, input bit j,
                      input bit jl, input logic [7:0] jt, input bit r, input logic [7:0] jr);
      stall = s; branch_taken = br; branch_target = bt; jump = j; jal = jl;
      jump_target = jt; ret = r; jr_target = jr;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      check("rst_pc_lit", 32'(pc_output), 32'h0);
      check("rst_empty_lit", 32'(ras_empty), 32'h1);
      @(posedge clk);
      #1;
      compare_all();
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] jr_r;
      model_reset();
      @(posedge clk);
      #1;
      compare_all();
      check("init_pc_lit", 32'(pc_output), 32'h0);
      rst = 1'b0;

      // Sequential wrap
      cyc(0, 0, 8'h00, 1, 0, 8'hFE, 0, 8'h00);
      cyc(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00);
      check("wrap_ff_lit", 32'(pc_output), 32'hFF);
      cyc(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00);
      check("wrap_00_lit", 32'(pc_output), 32'h00);

      // Priority and stall
      cyc(0, 1, 8'h40, 1, 0, 8'h80, 0, 8'h00);
      check("prio_lit", 32'(pc_output), 32'h80);
      cyc(1, 1, 8'h40, 1, 0, 8'h90, 0, 8'h00);
      check("stall_lit", 32'(pc_output), 32'h80);

      // Call / return
      cyc(0, 0, 8'h00, 1, 0, 8'h10, 0, 8'h00);
      cyc(0, 0, 8'h00, 0, 1, 8'h50, 0, 8'h00);
      check("jal_lit", 32'(pc_output), 32'h50);
      cyc(0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h11);
      check("ret_lit", 32'(pc_output), 32'h11);
      check("ret_empty_lit", 32'(ras_empty), 32'h1);

      // Overflow then drain and underflow
      cyc(0, 0, 8'h00, 1, 0, 8'h01, 0, 8'h00);
      cyc(0, 0, 8'h00, 0, 1, 8'h05, 0, 8'h00);
      cyc(0, 0, 8'h00, 0, 1, 8'h09, 0, 8'h00);
      cyc(0, 0, 8'h00, 0, 1, 8'h0D, 0, 8'h00);
      cyc(0, 0, 8'h00, 0, 1, 8'h11, 0, 8'h00);
      cyc(0, 0, 8'h00, 0, 1, 8'h20, 0, 8'h00);
      check("ovf_lit", 32'(ras_overflow), 32'h1);
      check("full_lit", 32'(ras_full), 32'h1);
      cyc(0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h12);
      check("pop1_lit", 32'(pc_output), 32'h12);
      cyc(0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h0E);
      check("pop2_lit", 32'(pc_output), 32'h0E);
      cyc(0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h0A);
      check("pop3_lit", 32'(pc_output), 32'h0A);
      cyc(0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h06);
      check("pop4_lit", 32'(pc_output), 32'h06);
      cyc(0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h33);
      check("unf_pc_lit", 32'(pc_output), 32'h33);
      check("unf_pulse_lit", 32'(ras_underflow), 32'h1);
      cyc(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00);
      check("unf_clear_lit", 32'(ras_underflow), 32'h0);

      // Mid-run reset with PC=0x37 and two RAS entries
      cyc(0, 0, 8'h00, 0, 1, 8'h36, 0, 8'h00);
      cyc(0, 0, 8'h00, 0, 1, 8'h37, 0, 8'h00);
      check("pre_rst_pc_lit", 32'(pc_output), 32'h37);
      do_reset();
      check("rst_ovf_lit", 32'(ras_overflow), 32'h0);

      // Return-address check against jr_target
      cyc(0, 0, 8'h00, 1, 0, 8'h20, 0, 8'h00);
      cyc(0, 0, 8'h00, 0, 1, 8'h70, 0, 8'h00);
      cyc(0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h60);
`ifdef PC_RAS_CHECK_EN
      check("mm_pc_lit", 32'(pc_output), 32'h60);
      check("mm_pulse_lit", 32'(ras_mismatch), 32'h1);
`else
      check("nomm_pc_lit", 32'(pc_output), 32'h21);
      check("nomm_flag_lit", 32'(ras_mismatch), 32'h0);
`endif
      check("mm_empty_lit", 32'(ras_empty), 32'h1);
      cyc(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00);
      check("mm_clear_lit", 32'(ras_mismatch), 32'h0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
         end else begin
            jr_r = 8'($urandom);
            if (m_ras.size() > 0 && $urandom_range(0, 3) != 0) jr_r = m_ras[$];
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, 8'($urandom),
                $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, 8'($urandom),
                $urandom_range(0, 2) == 0, jr_r);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
